// File: rtl/stopwatch_lap_timer.sv
`default_nettype none
// ============================================================================
// Module  : stopwatch_lap_timer
// Brief   : MM:SS.CC up/down stopwatch-timer with key debounce, lap buffer
//           and a registered BCD display output.
// Rev     : 1.0 - initial release
// ============================================================================
module stopwatch_lap_timer #(
  parameter int TICK_DIV  = 500000,
  parameter int DEBOUNCE  = 10000000,
  parameter int LAP_DEPTH = 4,
  parameter int LAP_AW    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              key_start_pause,
  input  logic              key_lap,
  input  logic              key_clear,
  input  logic              mode_down,
  input  logic [23:0]       preload,
  input  logic              show_lap,
  input  logic [LAP_AW-1:0] lap_sel,
  output logic [23:0]       disp_bcd,
  output logic [LAP_AW:0]   lap_count,
  output logic              running,
  output logic              expired,
  output logic [3:0]        led
);

  localparam int              PW        = $clog2(TICK_DIV);
  localparam int              DW        = $clog2(DEBOUNCE + 1);
  localparam logic [PW-1:0]   TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0]   DEB_LAST  = DW'(DEBOUNCE - 1);
  localparam logic [DW-1:0]   DEB_MAX   = DW'(DEBOUNCE);
  localparam logic [LAP_AW:0] LAP_FULL  = (LAP_AW + 1)'(LAP_DEPTH);
  localparam logic [23:0]     BLANK     = 24'hBBBBBB;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [23:0]   count, count_next, lap_view, disp_nxt;
  logic [PW-1:0] presc;
  logic          mode, tick, do_clear, lap_take;
  logic [2:0]    key_raw, press;
  logic          start_p, lap_p, clear_p;
  logic [23:0]   laps [LAP_DEPTH];

  // Digit index 3 is S1 (tens of seconds, 0..5); all other digits run 0..9.
  function automatic logic [23:0] bcd_step(input logic [23:0] v, input logic down);
    logic [23:0] r;
    logic        carry;
    logic [3:0]  d, lim;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 6; i++) begin
      d   = v[i*4 +: 4];
      lim = (i == 3) ? 4'd5 : 4'd9;
      if (carry) begin
        if (down) begin
          if (d == 4'd0) r[i*4 +: 4] = lim;
          else begin
            r[i*4 +: 4] = d - 4'd1;
            carry       = 1'b0;
          end
        end else begin
          if (d >= lim) r[i*4 +: 4] = 4'd0;
          else begin
            r[i*4 +: 4] = d + 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  function automatic logic [23:0] bcd_clamp(input logic [23:0] v);
    logic [23:0] r;
    logic [3:0]  d, lim;
    r = v;
    for (int i = 0; i < 6; i++) begin
      d           = v[i*4 +: 4];
      lim         = (i == 3) ? 4'd5 : 4'd9;
      r[i*4 +: 4] = (d > lim) ? lim : d;
    end
    return r;
  endfunction

  assign key_raw = {key_clear, key_lap, key_start_pause};

  for (genvar k = 0; k < 3; k++) begin : g_debounce
    logic [DW-1:0] db_cnt;
    always_ff @(posedge clk) begin
      if (reset || key_raw[k]) db_cnt <= '0;
      else if (db_cnt != DEB_MAX) db_cnt <= db_cnt + 1'b1;
    end
    assign press[k] = !key_raw[k] && (db_cnt == DEB_LAST);
  end

  assign start_p = press[0];
  assign lap_p   = press[1];
  assign clear_p = press[2];

  always_comb begin
    tick       = (state == RUN) && (presc == TICK_LAST);
    count_next = bcd_step(count, mode);
    do_clear   = clear_p && (state != RUN);
    lap_take   = lap_p && (state == RUN) && (lap_count < LAP_FULL);
    state_nxt  = state;
    case (state)
      IDLE: begin
        if (!clear_p && start_p && !(mode && count == '0)) state_nxt = RUN;
      end
      RUN: begin
        // Expiry outranks a coincident pause request.
        if (tick && mode && count_next == '0) state_nxt = EXPIRED;
        else if (start_p)                     state_nxt = PAUSE;
      end
      PAUSE: begin
        if (clear_p)      state_nxt = IDLE;
        else if (start_p) state_nxt = RUN;
      end
      EXPIRED: begin
        if (clear_p) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      presc     <= '0;
      mode      <= mode_down;
      lap_count <= '0;
      disp_bcd  <= '0;
    end else begin
      state    <= state_nxt;
      disp_bcd <= disp_nxt;
      if (do_clear) begin
        mode      <= mode_down;
        count     <= mode_down ? bcd_clamp(preload) : 24'h000000;
        presc     <= '0;
        lap_count <= '0;
      end else begin
        if (state == RUN) presc <= tick ? '0 : presc + 1'b1;
        if (tick)         count <= count_next;
        if (lap_take)     lap_count <= lap_count + 1'b1;
      end
    end
  end

  // Laps store the pre-tick count, since count is only updated at this edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LAP_DEPTH; i++) laps[i] <= '0;
    end else if (lap_take) begin
      for (int i = 0; i < LAP_DEPTH; i++)
        if (lap_count == (LAP_AW + 1)'(i)) laps[i] <= count;
    end
  end

  always_comb begin
    lap_view = BLANK;
    for (int i = 0; i < LAP_DEPTH; i++)
      if (lap_sel == LAP_AW'(i) && (LAP_AW + 1)'(i) < lap_count) lap_view = laps[i];
    disp_nxt = show_lap ? lap_view : count;
  end

  assign running = (state == RUN);
  assign expired = (state == EXPIRED);
  assign led     = {mode, expired, (lap_count == LAP_FULL), running};

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_lap_timer.sv
`default_nettype none
// ============================================================================
// Module  : tb_stopwatch_lap_timer
// Brief   : Directed self-checking bench for stopwatch_lap_timer.
// Rev     : 1.0 - initial release
// ============================================================================
module tb_stopwatch_lap_timer;
  localparam int LAP_AW = 2;

  logic              clk = 1'b0;
  logic              reset, ksp, klap, kclr, mode_down, show_lap;
  logic [23:0]       preload, disp_bcd;
  logic [LAP_AW-1:0] lap_sel;
  logic [LAP_AW:0]   lap_count;
  logic              running, expired;
  logic [3:0]        led;
  int                errors = 0;
  int                checks = 0;
  logic [23:0]       lap_exp [4];

  stopwatch_lap_timer #(
    .TICK_DIV(4), .DEBOUNCE(3), .LAP_DEPTH(4), .LAP_AW(LAP_AW)
  ) dut (
    .clk(clk), .reset(reset),
    .key_start_pause(ksp), .key_lap(klap), .key_clear(kclr),
    .mode_down(mode_down), .preload(preload),
    .show_lap(show_lap), .lap_sel(lap_sel),
    .disp_bcd(disp_bcd), .lap_count(lap_count),
    .running(running), .expired(expired), .led(led)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // 0 = start/pause, 1 = lap, 2 = clear; the pulse acts on the third edge.
  task automatic press(input int which);
    case (which)
      0: ksp  = 1'b0;
      1: klap = 1'b0;
      default: kclr = 1'b0;
    endcase
    step(3);
    ksp = 1'b1; klap = 1'b1; kclr = 1'b1;
  endtask

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    lap_exp[0] = 24'h000002; lap_exp[1] = 24'h000004;
    lap_exp[2] = 24'h000005; lap_exp[3] = 24'h000007;
    reset = 1'b1; ksp = 1'b1; klap = 1'b1; kclr = 1'b1;
    mode_down = 1'b0; preload = '0; show_lap = 1'b0; lap_sel = '0;
    step(2);
    check("rst_disp", disp_bcd, 24'h0);
    check("rst_laps", 24'(lap_count), 24'h0);
    check("rst_running", 24'(running), 24'h0);
    check("rst_expired", 24'(expired), 24'h0);
    check("rst_led", 24'(led), 24'h0);
    reset = 1'b0;

    // Debounce
    ksp = 1'b0; step(2); ksp = 1'b1; step(1);
    check("short_press", 24'(running), 24'h0);
    ksp = 1'b0; step(10);
    check("held_running", 24'(running), 24'h1);
    check("held_led0", 24'(led[0]), 24'h1);
    ksp = 1'b1; step(1);
    press(0);
    check("repress_pause", 24'(running), 24'h0);
    step(1); press(2); step(1);
    check("clear_zero", disp_bcd, 24'h0);

    // Up count, pause, resume without lost prescaler phase
    press(0); step(402);
    check("up_100_ticks", disp_bcd, 24'h000100);
    press(0); step(50);
    check("pause_hold", disp_bcd, 24'h000101);
    check("pause_running", 24'(running), 24'h0);
    press(0); step(3);
    check("resume_before_tick", disp_bcd, 24'h000101);
    step(1);
    check("resume_tick", disp_bcd, 24'h000102);

    // Wrap boundaries
    press(0);
    force dut.count = 24'h995999; #1; release dut.count;
    step(1);
    check("forced_max", disp_bcd, 24'h995999);
    press(0); step(5);
    check("wrap_zero", disp_bcd, 24'h000000);
    check("wrap_running", 24'(running), 24'h1);
    press(0);
    force dut.count = 24'h005999; #1; release dut.count;
    step(1);
    check("forced_5999", disp_bcd, 24'h005999);
    press(0); step(5);
    check("minute_carry", disp_bcd, 24'h010000);

    // Down timer
    press(0);
    mode_down = 1'b1; preload = 24'h000003;
    press(2); step(1);
    check("timer_load", disp_bcd, 24'h000003);
    check("timer_led", 24'(led), 24'h8);
    press(0); step(11);
    check("timer_not_yet", 24'(expired), 24'h0);
    check("timer_disp1", disp_bcd, 24'h000001);
    step(1);
    check("timer_expired", 24'(expired), 24'h1);
    check("timer_exp_led", 24'(led), 24'hC);
    check("timer_exp_run", 24'(running), 24'h0);
    step(1);
    check("timer_zero", disp_bcd, 24'h0);
    press(0); step(1);
    check("exp_start_ign", 24'(expired), 24'h1);
    check("exp_hold_zero", disp_bcd, 24'h0);
    press(2); step(1);
    check("timer_reload", disp_bcd, 24'h000003);
    check("reload_not_exp", 24'(expired), 24'h0);
    preload = 24'h9F7AC5;
    press(2); step(1);
    check("sanitise", disp_bcd, 24'h995995);
    preload = 24'h000000;
    press(2); step(1); press(0); step(1);
    check("zero_start_idle", 24'(running), 24'h0);
    mode_down = 1'b0;
    press(2); step(1);
    check("up_clear", disp_bcd, 24'h0);
    check("up_led", 24'(led), 24'h0);

    // Laps, including one coinciding with a tick
    press(0); step(8);
    press(1);
    check("lap1_count", 24'(lap_count), 24'h1);
    step(5); press(1);
    step(2); press(1);
    step(4); press(1);
    check("lap4_count", 24'(lap_count), 24'h4);
    check("lap_full_led", 24'(led), 24'h3);
    step(4); press(1);
    check("lap5_dropped", 24'(lap_count), 24'h4);
    press(2);
    check("run_clear_ign", 24'(running), 24'h1);
    check("run_clear_laps", 24'(lap_count), 24'h4);
    show_lap = 1'b1;
    for (int i = 0; i < 4; i++) begin
      lap_sel = LAP_AW'(i);
      step(1);
      check($sformatf("lap_read%0d", i), disp_bcd, lap_exp[i]);
    end
    show_lap = 1'b0;
    press(0); step(1); press(2); step(1);
    show_lap = 1'b1; lap_sel = '0; step(1);
    check("lap_blank0", disp_bcd, 24'hBBBBBB);
    check("lap_cleared", 24'(lap_count), 24'h0);
    lap_sel = 2'd3; step(1);
    check("lap_blank3", disp_bcd, 24'hBBBBBB);
    show_lap = 1'b0;

    // Reset mid-run with a lap pulse due in the same cycle
    press(0); step(10); press(1); step(1);
    check("pre_reset_lap", 24'(lap_count), 24'h1);
    klap = 1'b0; step(2);
    reset = 1'b1; mode_down = 1'b1; step(1);
    check("mid_rst_disp", disp_bcd, 24'h0);
    check("mid_rst_laps", 24'(lap_count), 24'h0);
    check("mid_rst_run", 24'(running), 24'h0);
    check("mid_rst_exp", 24'(expired), 24'h0);
    check("mid_rst_led", 24'(led), 24'h8);
    reset = 1'b0; klap = 1'b1; mode_down = 1'b0;
    step(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
